sram_rr_arbiter: RTL and testbench
==================================

// Module: sram_rr_arbiter
// PURPOSE
// - Shares one single-port SRAM (single_port_ram_intf, compute modport) among NUM_REQ
//   requesters, e.g. weight loader, activation fetch and result writeback.
// - Round-robin arbitration accepts at most one access per cycle.
// - Drives registered cs/oe/W_req/addr/W_data into the RAM.
// - Returns read data to the issuing requester with a tagged rvalid.
// PARAMETERS
// - NUM_REQ  3            number of requesters (>=2)
// - ADDR_W   `ADDR_WIDTH  address width (define.v)
// - DATA_W   `DATA_WIDTH  data width (define.v)
// - IDX_W    $clog2(NUM_REQ)  derived, not overridden
// PORTS
// - clk       in   1               clock; all state on posedge
// - rst_n     in   1               async active-low reset
// - req       in   NUM_REQ         request valid per requester
// - we        in   NUM_REQ         1 = write, 0 = read
// - addr      in   NUM_REQ*ADDR_W  packed per-requester address
// - wdata     in   NUM_REQ*DATA_W  packed per-requester write data
// - gnt       out  NUM_REQ         one-hot accept; beat taken at edge where req&gnt
// - rvalid    out  NUM_REQ         one-hot read-data-valid
// - rdata     out  DATA_W          read data, broadcast; valid where rvalid set
// - mem       intf -               single_port_ram_intf.compute
// - lock      in   NUM_REQ         only with SRAM_ARB_LOCK_EN
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - cs, oe, W_req, addr, W_data = 0; rvalid = 0.
//   - RR pointer = 0; in-flight read tag cleared.
// - gnt is combinational from req and the registered pointer:
//   - Grant the first requesting index at or after ptr, wrapping NUM_REQ-1 -> 0.
//   - gnt is zero-or-one-hot; gnt=0 when req=0.
// - Acceptance at edge n (req[i]&gnt[i]):
//   - ptr <= (i+1) mod NUM_REQ.
//   - Cycle n: cs=1, addr/W_data = requester i's values.
//   - Write: W_req=1, oe=0. Read: W_req=0, oe=1.
// - No acceptance at edge n: cs=oe=W_req=0 in cycle n; addr/W_data hold.
// - Read latency:
//   - RAM samples at edge n+1 and R_data is valid in cycle n+1.
//   - rvalid[i]=1 in cycle n+1 only; rdata = mem.R_data (combinational passthrough).
// - Writes produce no rvalid.
// - Throughput and fairness:
//   - Back-to-back accepts allowed: one per cycle, mixed read/write.
//   - Read pipeline holds one tag register.
//   - With all requesters active, each is granted once every NUM_REQ cycles.
//   - No requester waits more than NUM_REQ-1 cycles.
// - Requester inputs may change freely while req=1 and gnt=0; they are sampled only on acceptance.
// - Requester dropping req before grant: no access, no pointer change.
// - Reset mid-read: pending rvalid is dropped and never emitted.
// CONFIGURATION
// - Macro SRAM_ARB_LOCK_EN defined:
//   - lock port present.
//   - Acceptance with lock[i]=1 makes i the owner; gnt is forced to i alone while the owner holds req.
//   - Ownership ends on an accepted owner beat with lock[i]=0, or on a cycle with req[i]=0.
//   - ptr advances past the owner on release.
// - Macro undefined:
//   - lock port absent; pure round-robin.
// STRUCTURE
// - Package sram_arb_pkg:
//   - NUM_REQ default.
//   - typedef idx_t (IDX_W bits).
//   - typedef struct packed mem_cmd_t {we, addr, wdata}.
//   - Function rr_pick(req, ptr) -> idx_t plus a found flag.
// - Sub-module sram_rr_pick: combinational rotate / priority-encode / unrotate yielding one-hot gnt.
// - Top-level: pointer register, command output register, read tag register, optional lock FSM
//   (IDLE, LOCKED).
// TESTING
// - Single req[1] read addr 0x10 held 4 cycles:
//   - gnt[1] every cycle; cs=oe=1 cycles n..n+3.
//   - rvalid[1] cycles n+1..n+4 with RAM contents of 0x10.
// - All 3 requesters request continuously:
//   - gnt order 0,1,2,0,1,2; no gaps; rvalid tags match issue order.
// - req[2] write 0x5 <- 0xA5, then req[0] read 0x5 next cycle:
//   - W_req=1 in first command cycle; rvalid[0] with rdata=0xA5.
// - Assert rst_n=0 the cycle after a read acceptance:
//   - All outputs 0 immediately; no rvalid after release; ptr=0.
// - ptr=2, req=3'b011:
//   - Grant wraps to 0, then 1; req=0 gives cs=0 and gnt=0.
// - SRAM_ARB_LOCK_EN, req[1] locked for 3 beats with req[0] active:
//   - gnt[1] x3 then gnt[0]; req[1] dropping mid-lock releases ownership the next cycle.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared types and helpers for the SRAM round-robin arbiter.
//   - DEFAULT_NUM_REQ : default requester count
//   - idx_t           : requester index for the default configuration
//   - mem_cmd_t       : one RAM command {we, addr, wdata} at default widths
//   - lock_state_t    : ownership FSM states (used when SRAM_ARB_LOCK_EN is defined)
//   - rr_pick()       : rotate / priority-encode / unrotate round-robin selection
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package sram_arb_pkg;

    localparam int unsigned DEFAULT_NUM_REQ = 3;
    localparam int unsigned IDX_W           = $clog2(DEFAULT_NUM_REQ);

    // rr_pick works on a fixed-width vector so any NUM_REQ up to MAX_REQ can share it
    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned PICK_W  = $clog2(MAX_REQ);

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic                   we;
        logic [`ADDR_WIDTH-1:0] addr;
        logic [`DATA_WIDTH-1:0] wdata;
    } mem_cmd_t;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } lock_state_t;

    // First set bit of req at or after ptr, wrapping n-1 -> 0. Requires ptr < n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input int unsigned        ptr,
                                      input int unsigned        n);
        logic [MAX_REQ-1:0] rot;
        int unsigned        j;
        pick_t              r;
        rot = '0;
        r   = '0;
        // rotate so that position 0 corresponds to ptr
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) j = j - n;
                rot[PICK_W'(k)] = req[PICK_W'(j)];
            end
        end
        // lowest set bit wins, then map back to the real index
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (!r.found && rot[PICK_W'(k)]) begin
                r.found = 1'b1;
                j = ptr + k;
                if (j >= n) j = j - n;
                r.idx = PICK_W'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/single_port_ram_intf.sv
// single_port_ram_intf
//   Connection to a single-port synchronous SRAM.
//   - cs, oe, W_req, addr, W_data : command from the compute side
//   - R_data                      : read data, valid the cycle after a read command
//   Modports: compute (drives commands), memory (the RAM itself).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface single_port_ram_intf #(
    parameter int unsigned ADDR_W = `ADDR_WIDTH,
    parameter int unsigned DATA_W = `DATA_WIDTH
);
    logic              cs;
    logic              oe;
    logic              W_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] W_data;
    logic [DATA_W-1:0] R_data;

    modport compute (output cs, output oe, output W_req, output addr, output W_data,
                     input  R_data);
    modport memory  (input  cs, input  oe, input  W_req, input  addr, input  W_data,
                     output R_data);
endinterface

// File: rtl/sram_rr_pick.sv
// sram_rr_pick
//   Combinational round-robin selector.
//   - req   : request vector
//   - ptr   : highest-priority index this cycle
//   - gnt   : one-hot grant (zero when req is zero)
//   - idx   : index of the granted requester
//   - found : any requester granted
module sram_rr_pick
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned SEL_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(req), 32'(ptr), NUM_REQ);
        found = pick.found;
        idx   = pick.idx[SEL_W-1:0];
        gnt   = '0;
        if (pick.found) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter
//   Shares one single-port SRAM among NUM_REQ requesters with round-robin
//   arbitration, one accepted access per cycle, registered RAM command and
//   tagged read-data return one cycle after the command.
//   Ports:
//   - clk, rst_n : clock, asynchronous active-low reset
//   - req, we    : per-requester valid and write flag
//   - addr/wdata : packed per-requester address / write data
//   - gnt        : combinational one-hot accept (beat taken where req & gnt)
//   - rvalid     : one-hot read-data-valid, rdata broadcast from mem.R_data
//   - mem        : single_port_ram_intf.compute
//   - lock       : only when SRAM_ARB_LOCK_EN is defined; holds grant on an owner
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter  int unsigned ADDR_W  = `ADDR_WIDTH,
    parameter  int unsigned DATA_W  = `DATA_WIDTH,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DATA_W-1:0]     rdata,
    single_port_ram_intf.compute  mem
`ifdef SRAM_ARB_LOCK_EN
   ,input  logic [NUM_REQ-1:0]    lock
`endif
);

    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               acc;
    logic [IDX_W-1:0]   acc_idx;

    logic               cmd_cs;
    logic               cmd_oe;
    logic               cmd_wreq;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [DATA_W-1:0]  cmd_wdata;
    logic [IDX_W-1:0]   cmd_tag;

    sram_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .gnt   (rr_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef SRAM_ARB_LOCK_EN
    lock_state_t      lock_state, lock_next;
    logic [IDX_W-1:0] owner, owner_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state <= ARB_IDLE;
            owner      <= '0;
        end else begin
            lock_state <= lock_next;
            owner      <= owner_next;
        end
    end

    // While locked the owner alone is granted; a cycle with the owner's req
    // low grants nobody and drops ownership, so others compete from the next cycle.
    always_comb begin
        lock_next  = lock_state;
        owner_next = owner;
        gnt        = rr_gnt;
        acc        = pick_found;
        acc_idx    = pick_idx;
        case (lock_state)
            ARB_IDLE: begin
                if (pick_found && lock[pick_idx]) begin
                    lock_next  = ARB_LOCKED;
                    owner_next = pick_idx;
                end
            end
            ARB_LOCKED: begin
                gnt = '0;
                if (req[owner]) begin
                    gnt[owner] = 1'b1;
                    acc        = 1'b1;
                    acc_idx    = owner;
                    if (!lock[owner]) lock_next = ARB_IDLE;
                end else begin
                    acc       = 1'b0;
                    lock_next = ARB_IDLE;
                end
            end
            default: lock_next = ARB_IDLE;
        endcase
    end
`else
    always_comb begin
        gnt     = rr_gnt;
        acc     = pick_found;
        acc_idx = pick_idx;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            cmd_cs    <= 1'b0;
            cmd_oe    <= 1'b0;
            cmd_wreq  <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_tag   <= '0;
            rvalid    <= '0;
        end else begin
            // the RAM samples the current read command at this edge, so its
            // data and the matching rvalid appear together next cycle
            rvalid <= '0;
            if (cmd_cs && cmd_oe) rvalid[cmd_tag] <= 1'b1;

            cmd_cs   <= acc;
            cmd_oe   <= acc && !we[acc_idx];
            cmd_wreq <= acc && we[acc_idx];
            if (acc) begin
                ptr       <= (acc_idx == IDX_W'(NUM_REQ - 1)) ? '0 : acc_idx + 1'b1;
                cmd_addr  <= addr[32'(acc_idx)*ADDR_W +: ADDR_W];
                cmd_wdata <= wdata[32'(acc_idx)*DATA_W +: DATA_W];
                cmd_tag   <= acc_idx;
            end
        end
    end

    assign mem.cs     = cmd_cs;
    assign mem.oe     = cmd_oe;
    assign mem.W_req  = cmd_wreq;
    assign mem.addr   = cmd_addr;
    assign mem.W_data = cmd_wdata;
    assign rdata      = mem.R_data;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter
//   Directed bench for sram_rr_arbiter with a behavioural synchronous RAM.
//   RAM is preloaded with C000 | address.
module tb_sram_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 10;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, we, gnt, rvalid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata;
`ifdef SRAM_ARB_LOCK_EN
    logic [N-1:0]    lock;
`endif

    int checks = 0;
    int errors = 0;

    single_port_ram_intf #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

    logic [DW-1:0] ram [0:(1<<AW)-1];

    sram_rr_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .mem    (ram_if)
`ifdef SRAM_ARB_LOCK_EN
       ,.lock   (lock)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_if.cs && ram_if.W_req) ram[ram_if.addr] <= ram_if.W_data;
        if (ram_if.cs && ram_if.oe)    ram_if.R_data    <= ram[ram_if.addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[i]             = w;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    initial begin
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
`ifdef SRAM_ARB_LOCK_EN
        lock  = '0;
`endif
        for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(32'hC000 | i);
        rst_n = 1'b0;
        #12;
        check("rst_cs",     ram_if.cs,     0);
        check("rst_oe",     ram_if.oe,     0);
        check("rst_wreq",   ram_if.W_req,  0);
        check("rst_addr",   ram_if.addr,   0);
        check("rst_wdata",  ram_if.W_data, 0);
        check("rst_rvalid", rvalid,        0);
        check("rst_gnt",    gnt,           0);
        rst_n = 1'b1;
        tick;

        // single requester 1 reading 0x10 for four beats
        set_req(1, 1'b0, 10'h010, '0);
        req = 3'b010;
        #1;
        for (int c = 0; c < 4; c++) begin
            check("t1_gnt", gnt, 3'b010);
            tick;
            check("t1_cs",   ram_if.cs,   1);
            check("t1_oe",   ram_if.oe,   1);
            check("t1_wreq", ram_if.W_req, 0);
            check("t1_addr", ram_if.addr, 10'h010);
            if (c == 0) check("t1_rv0", rvalid, 0);
            else begin
                check("t1_rv", rvalid, 3'b010);
                check("t1_rd", rdata,  16'hC010);
            end
        end
        req = '0;
        tick;
        check("t1_cs_end", ram_if.cs, 0);
        check("t1_rv_end", rvalid,    3'b010);
        check("t1_rd_end", rdata,     16'hC010);
        tick;
        check("t1_rv_off", rvalid, 0);

        // ptr is 2: req=011 wraps to 0, then 1
        set_req(0, 1'b0, 10'h040, '0);
        set_req(1, 1'b0, 10'h041, '0);
        req = 3'b011;
        #1;
        check("t5_gnt0", gnt, 3'b001);
        tick;
        check("t5_addr0", ram_if.addr, 10'h040);
        check("t5_gnt1",  gnt, 3'b010);
        tick;
        check("t5_addr1", ram_if.addr, 10'h041);
        req = '0;
        #1;
        check("t5_gnt_none", gnt, 0);
        tick;
        check("t5_cs_idle",   ram_if.cs,   0);
        check("t5_addr_hold", ram_if.addr, 10'h041);
        check("t5_rv",        rvalid,      3'b010);
        check("t5_rd",        rdata,       16'hC041);
        tick;

        // reset in the cycle after a read acceptance
        set_req(0, 1'b0, 10'h030, '0);
        req = 3'b001;
        #1;
        check("t4_gnt", gnt, 3'b001);
        tick;
        check("t4_cs", ram_if.cs, 1);
        rst_n = 1'b0;
        req   = '0;
        #1;
        check("t4_cs0",    ram_if.cs,     0);
        check("t4_oe0",    ram_if.oe,     0);
        check("t4_addr0",  ram_if.addr,   0);
        check("t4_rv0",    rvalid,        0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick;
        check("t4_rv_rel0", rvalid, 0);
        tick;
        check("t4_rv_rel1", rvalid, 0);

        // all three continuously; first grant to 0 also shows ptr was reset
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(10'h020 + i), '0);
        req = 3'b111;
        #1;
        for (int k = 0; k < 6; k++) begin
            check("t2_gnt", gnt, 3'b001 << (k % 3));
            tick;
            check("t2_cs",   ram_if.cs,   1);
            check("t2_addr", ram_if.addr, 10'h020 + (k % 3));
            if (k > 0) begin
                check("t2_rv", rvalid, 3'b001 << ((k - 1) % 3));
                check("t2_rd", rdata,  16'hC020 + ((k - 1) % 3));
            end
        end
        req = '0;
        tick;
        check("t2_cs_end", ram_if.cs, 0);
        check("t2_rv_end", rvalid,    3'b100);
        check("t2_rd_end", rdata,     16'hC022);

        // write from 2 then read-back from 0
        set_req(2, 1'b1, 10'h005, 16'h00A5);
        req = 3'b100;
        #1;
        check("t3_gnt_w", gnt, 3'b100);
        tick;
        check("t3_cs",    ram_if.cs,     1);
        check("t3_wreq",  ram_if.W_req,  1);
        check("t3_oe",    ram_if.oe,     0);
        check("t3_addr",  ram_if.addr,   10'h005);
        check("t3_wdata", ram_if.W_data, 16'h00A5);
        set_req(0, 1'b0, 10'h005, '0);
        req = 3'b001;
        #1;
        check("t3_gnt_r", gnt, 3'b001);
        tick;
        check("t3_oe_r",   ram_if.oe,    1);
        check("t3_wreq_r", ram_if.W_req, 0);
        check("t3_rv_w",   rvalid,       0);
        req = '0;
        tick;
        check("t3_rv", rvalid, 3'b001);
        check("t3_rd", rdata,  16'h00A5);
        tick;

`ifdef SRAM_ARB_LOCK_EN
        // ptr is 1: requester 1 locks for three beats while 0 keeps requesting
        set_req(0, 1'b0, 10'h050, '0);
        set_req(1, 1'b0, 10'h051, '0);
        req  = 3'b011;
        lock = 3'b010;
        #1;
        check("lk_gnt1", gnt, 3'b010);
        tick;
        check("lk_gnt2", gnt, 3'b010);
        tick;
        lock = 3'b000;
        #1;
        check("lk_gnt3", gnt, 3'b010);
        tick;
        check("lk_after", gnt, 3'b001);
        req  = 3'b010;
        lock = 3'b010;
        #1;
        check("lk_relock", gnt, 3'b010);
        tick;
        req = 3'b001;
        #1;
        check("lk_drop", gnt, 3'b000);
        tick;
        check("lk_free", gnt, 3'b001);
        req  = '0;
        lock = '0;
        tick;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
